// File: rtl/booth_mult_seq_if.sv
// Request/response bundle for the sequential Booth multiplier: operands and start in,
// ready/busy/valid status and the 2N-bit product out.
interface booth_mult_seq_if #(
    parameter int unsigned N = 8
);
    logic           start;
    logic           signed_mode;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic           ready;
    logic           busy;
    logic           valid;
    logic [2*N-1:0] Y;

    modport master (
        output start, signed_mode, A, B,
        input  ready, busy, valid, Y
    );

    modport slave (
        input  start, signed_mode, A, B,
        output ready, busy, valid, Y
    );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, N-bit signed or unsigned operands, 2N-bit product.
// Runs N+1 add/shift steps on an (N+1)-bit datapath, so latency is mode-independent.
module booth_mult_seq #(
    parameter int unsigned N = 8
) (
    input logic              clk,
    input logic              rst,
    booth_mult_seq_if.slave  bus
);
    localparam int unsigned W    = N + 1;
    localparam int unsigned CntW = $clog2(N + 1);
    localparam logic [CntW-1:0] CntInit = CntW'(N);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   m_q, m_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   q_q, q_d;
    logic           q1_q, q1_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2*N-1:0] y_q, y_d;

    logic [W-1:0]   sum;
    logic [W-1:0]   acc_sh;
    logic [W-1:0]   q_sh;

    // One Booth step: conditional add/subtract of M, then arithmetic shift of {ACC,Q,Q_1}.
    always_comb begin
        sum = acc_q;
        case ({q_q[0], q1_q})
            2'b01:   sum = acc_q + m_q;
            2'b10:   sum = acc_q - m_q;
            default: sum = acc_q;
        endcase
        acc_sh = {sum[W-1], sum[W-1:1]};
        q_sh   = {sum[0], q_q[W-1:1]};
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    m_d     = bus.signed_mode ? {bus.A[N-1], bus.A} : {1'b0, bus.A};
                    q_d     = bus.signed_mode ? {bus.B[N-1], bus.B} : {1'b0, bus.B};
                    acc_d   = '0;
                    q1_d    = 1'b0;
                    cnt_d   = CntInit;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                acc_d = acc_sh;
                q_d   = q_sh;
                q1_d  = q_q[0];
                if (cnt_q == '0) begin
                    // Low 2N bits of {ACC,Q}; the bit above is redundant sign/zero extension.
                    y_d     = {acc_sh[N-2:0], q_sh};
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    assign bus.ready = (state_q == StIdle);
    assign bus.busy  = (state_q == StCalc) || (state_q == StDone);
    assign bus.valid = (state_q == StDone);
    assign bus.Y     = y_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: vector table, random operands against an arithmetic model,
// and hand-written sequences for ignored starts, reset abort and back-to-back operation.
module tb_booth_mult_seq;
    localparam int unsigned N = 8;
    localparam int unsigned Lat = N + 2;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   vcount;
    int   cyc;

    booth_mult_seq_if #(.N(N)) bus ();

    booth_mult_seq #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.valid) vcount <= vcount + 1;

    typedef struct {
        bit             sm;
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] y;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Exact product computed from the operand values, truncated to 2N bits.
    function automatic logic [2*N-1:0] ref_mul(input bit sm, input logic [N-1:0] a,
                                                input logic [N-1:0] b);
        longint pa;
        longint pb;
        logic [63:0] p;
        pa = longint'(a);
        pb = longint'(b);
        if (sm && a[N-1]) pa = pa - (longint'(1) << N);
        if (sm && b[N-1]) pb = pb - (longint'(1) << N);
        p = 64'(pa * pb);
        return p[2*N-1:0];
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) check("wait_ready timeout", 0, 1);
    endtask

    // Issue one operation from a negedge; returns product and start-to-valid cycle count.
    task automatic run_op(input bit sm, input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [2*N-1:0] y, output int lat);
        wait_ready();
        bus.signed_mode = sm;
        bus.A = a;
        bus.B = b;
        bus.start = 1'b1;
        lat = 0;
        @(posedge clk);
        lat++;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        y = bus.Y;
        if (!bus.valid) check("valid timeout", 0, 1);
        @(negedge clk);
        check("ready after done", 32'(bus.ready), 1);
        check("valid one cycle", 32'(bus.valid), 0);
    endtask

    initial begin
        logic [2*N-1:0] y;
        int lat;
        int v0;
        int c1;
        int n;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        bit rsm;

        errors = 0;
        checks = 0;
        vcount = 0;
        cyc = 0;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.signed_mode = 1'b0;
        bus.A = '0;
        bus.B = '0;

        vecs[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[1] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[2] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
        vecs[3] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        vecs[4] = '{1'b0, 8'h80, 8'h7F, 16'h3F80};
        vecs[5] = '{1'b0, 8'h00, 8'hAB, 16'h0000};
        vecs[6] = '{1'b0, 8'h7F, 8'h7F, 16'h3F01};
        vecs[7] = '{1'b1, 8'h80, 8'hFF, 16'h0080};
        vecs[8] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vecs[9] = '{1'b1, 8'h05, 8'hFD, 16'hFFF1};

        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("reset ready", 32'(bus.ready), 1);
        check("reset busy", 32'(bus.busy), 0);
        check("reset valid", 32'(bus.valid), 0);
        check("reset Y", 32'(bus.Y), 0);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].sm, vecs[i].a, vecs[i].b, y, lat);
            check($sformatf("vec%0d Y", i), 32'(y), 32'(vecs[i].y));
            check($sformatf("vec%0d latency", i), 32'(lat), Lat);
        end

        for (int i = 0; i < 40; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rsm = 1'($urandom);
            run_op(rsm, ra, rb, y, lat);
            check($sformatf("rand%0d Y sm=%0d a=%0h b=%0h", i, rsm, ra, rb), 32'(y),
                  32'(ref_mul(rsm, ra, rb)));
        end

        // Starts during CALC and DONE must be ignored.
        wait_ready();
        v0 = vcount;
        bus.signed_mode = 1'b0;
        bus.A = 8'd3;
        bus.B = 8'd5;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.A = 8'd9;
        bus.B = 8'd9;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!bus.valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ignore: valid seen", 32'(bus.valid), 1);
        check("ignore: ready in done", 32'(bus.ready), 0);
        check("ignore: Y", 32'(bus.Y), 32'h000F);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        check("ignore: one result", 32'(vcount - v0), 1);
        check("ignore: Y held", 32'(bus.Y), 32'h000F);

        // Reset mid-operation aborts without a result.
        bus.A = 8'h12;
        bus.B = 8'h34;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        v0 = vcount;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort ready", 32'(bus.ready), 1);
        check("abort busy", 32'(bus.busy), 0);
        check("abort Y", 32'(bus.Y), 0);
        repeat (20) @(negedge clk);
        check("abort no valid", 32'(vcount - v0), 0);

        // start held high: back-to-back results N+3 cycles apart.
        bus.A = 8'h00;
        bus.B = 8'hAB;
        bus.start = 1'b1;
        @(negedge clk);
        bus.A = 8'h7F;
        bus.B = 8'h7F;
        n = 0;
        while (!bus.valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b first Y", 32'(bus.Y), 0);
        c1 = cyc;
        @(negedge clk);
        n = 0;
        while (!bus.valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check("b2b second Y", 32'(bus.Y), 32'h3F01);
        check("b2b spacing", 32'(cyc - c1), N + 3);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
